// File: rtl/srl_cascade_seq.sv
// Control sequencer for a cascaded SRLC32E chain: serial shift-in, full clear,
// and an address sweep that streams every stage's Q through a one-entry output slot.
module srl_cascade_seq #(
    parameter int N_STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [7:0]          cmd_len,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic                din_data,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [N_STAGES-1:0] dout_data,
    output logic [4:0]          dout_addr,
    input  logic [N_STAGES-1:0] srl_q,
    output logic [4:0]          srl_a,
    output logic                srl_ce,
    output logic                srl_d,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_READ  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam logic [8:0] CLEAR_LAST = 9'(32 * N_STAGES - 1);

    state_t              state_reg, state_next;
    logic [8:0]          cnt_reg, cnt_next;
    logic [4:0]          addr_reg, addr_next;
    logic                dout_valid_reg, dout_valid_next;
    logic [4:0]          dout_addr_reg, dout_addr_next;
    logic [N_STAGES-1:0] dout_data_reg, dout_data_next;
    logic                slot_free;
    logic                capture;
    logic                cnt_zero;

    // An unconsumed entry blocks further captures, so it is never overwritten.
    assign slot_free = !dout_valid_reg || dout_ready;
    assign capture   = (state_reg == S_READ) && slot_free;
    assign cnt_zero  = (cnt_reg == 9'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 9'd0;
            addr_reg       <= 5'd0;
            dout_valid_reg <= 1'b0;
            dout_addr_reg  <= 5'd0;
            dout_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            dout_valid_reg <= dout_valid_next;
            dout_addr_reg  <= dout_addr_next;
            dout_data_reg  <= dout_data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'd0: begin
                            state_next = S_SHIFT;
                            cnt_next   = {1'b0, cmd_len};
                        end
                        2'd1: begin
                            state_next = S_READ;
                            cnt_next   = {4'd0, cmd_len[4:0]};
                            addr_next  = 5'd0;
                        end
                        2'd2: begin
                            state_next = S_CLEAR;
                            cnt_next   = CLEAR_LAST;
                        end
                        default: state_next = S_IDLE;
                    endcase
                end
            end
            S_SHIFT: begin
                if (din_valid) begin
                    cnt_next = cnt_reg - 9'd1;
                    if (cnt_zero) state_next = S_IDLE;
                end
            end
            S_READ: begin
                if (slot_free) begin
                    cnt_next  = cnt_reg - 9'd1;
                    addr_next = addr_reg + 5'd1;
                    if (cnt_zero) state_next = S_IDLE;
                end
            end
            S_CLEAR: begin
                cnt_next = cnt_reg - 9'd1;
                if (cnt_zero) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dout_valid_next = dout_valid_reg;
        dout_addr_next  = dout_addr_reg;
        if (capture) begin
            dout_valid_next = 1'b1;
            dout_addr_next  = addr_reg;
        end else if (dout_ready) begin
            dout_valid_next = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_capture
            assign dout_data_next[gi] = capture ? srl_q[gi] : dout_data_reg[gi];
        end
    endgenerate

    // srl_a comes straight from addr_reg, so it is stable for the whole cycle before each capture.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        din_ready = 1'b0;
        srl_a     = 5'd0;
        srl_ce    = 1'b0;
        srl_d     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_SHIFT: begin
                din_ready = 1'b1;
                srl_ce    = din_valid;
                srl_d     = din_data;
            end
            S_READ:  srl_a  = addr_reg;
            S_CLEAR: srl_ce = 1'b1;
            default: ;
        endcase
    end

    assign dout_valid = dout_valid_reg;
    assign dout_addr  = dout_addr_reg;
    assign dout_data  = dout_data_reg;

endmodule
